// File: rtl/alu_seq.sv
// alu_seq: registered ALU. ADD/SUB/AND/OR/XOR/SHL/SHR complete in one cycle.
// MUL uses an iterative shift-add multiplier when ALU_SEQ_MUL_EN is defined.
// Without the macro, MUL completes in one cycle with err set and a zero result.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    // Architectural output registers.
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    // Single-cycle ALU outputs for the operands currently on the inputs.
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_e;

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign busy = (state_q == MULT);
`else
    assign busy = 1'b0;
`endif

    // Compute the result of a single-cycle operation from the live inputs.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        // Extra top bit catches carry/borrow; the shifts keep the last bit moved out.
        add_ext   = {1'b0, a} + {1'b0, b};
        sub_ext   = {1'b0, a} - {1'b0, b};
        shl_ext   = {1'b0, a} << b[3:0];
        shr_ext   = {a, 1'b0} >> b[3:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_ext[WIDTH-1:0];
                alu_carry = sub_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res   = shr_ext[WIDTH:1];
                alu_carry = shr_ext[0];
            end
            OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
                alu_err = 1'b1;
`endif
            end
        endcase
    end

    // Next-state logic: accept requests, step the multiplier, publish results.
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        done_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d  = MULT;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                    end else begin
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        err_d    = alu_err;
                        done_d   = 1'b1;
                    end
                end
            end
            MULT: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    result_d = acc_sum[WIDTH-1:0];
                    carry_d  = |acc_sum[2*WIDTH-1:WIDTH];
                    ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_sum[WIDTH-1:0] == '0);
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
        endcase
`else
        if (start) begin
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            err_d    = alu_err;
            done_d   = 1'b1;
        end
`endif
    end

    // State and output registers with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_MUL_EN
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign err    = err_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq. Random and directed operations are
// compared against an arithmetic reference model. MUL checks adapt to
// whether ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         ovf;
    logic         err;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         ovf;
        logic         err;
    } exp_t;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero),
        .ovf    (ovf),
        .err    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        longint       ux;
        longint       uy;
        longint       sx;
        longint       sy;
        longint       full;
        longint       sr;
        longint       modv;
        longint       smax;
        longint       smin;
        logic [W-1:0] r;
        int           amt;
        e    = '0;
        modv = longint'(1) << W;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = x[W-1] ? ux - modv : ux;
        sy   = y[W-1] ? uy - modv : uy;
        amt  = int'(y[3:0]);
        case (o)
            3'd0: begin
                full    = ux + uy;
                e.res   = W'(full % modv);
                e.carry = (full >= modv);
                sr      = sx + sy;
                e.ovf   = (sr > smax) || (sr < smin);
            end
            3'd1: begin
                full    = ux - uy + modv;
                e.res   = W'(full % modv);
                e.carry = (ux < uy);
                sr      = sx - sy;
                e.ovf   = (sr > smax) || (sr < smin);
            end
            3'd2: e.res = x & y;
            3'd3: e.res = x | y;
            3'd4: e.res = x ^ y;
            3'd5: begin
                r = x;
                for (int i = 0; i < amt; i++) begin
                    e.carry = r[W-1];
                    r       = {r[W-2:0], 1'b0};
                end
                e.res = r;
            end
            3'd6: begin
                r = x;
                for (int i = 0; i < amt; i++) begin
                    e.carry = r[0];
                    r       = {1'b0, r[W-1:1]};
                end
                e.res = r;
            end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                full    = ux * uy;
                e.res   = W'(full % modv);
                e.carry = (full / modv) != 0;
                e.ovf   = e.carry;
`else
                e.err   = 1'b1;
`endif
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Drive one request for a single edge and return at the sample point
    // where done should be high (after the multiply latency for MUL).
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        if (o == 3'd7) begin
            repeat (W) @(posedge clk);
            #1;
        end
`endif
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        #12;
        total++;
        if ({busy, done, result, carry, zero, ovf, err} !== {2'b00, {W{1'b0}}, 4'b0100}) begin
            $display("FAIL reset_values: got %h expected %h",
                     {busy, done, result, carry, zero, ovf, err}, {2'b00, {W{1'b0}}, 4'b0100});
        end else passed++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({busy, done, result, carry, zero, ovf, err} !== {2'b00, {W{1'b0}}, 4'b0100}) begin
            $display("FAIL reset_idle_after_release: got %h expected %h",
                     {busy, done, result, carry, zero, ovf, err}, {2'b00, {W{1'b0}}, 4'b0100});
        end else passed++;
    endtask

    task automatic test_directed();
        vec_t v[12];
        v = '{
            '{3'd0, 16'h7FFF, 16'h0001, '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b0}},
            '{3'd1, 16'h0003, 16'h0005, '{16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0}},
            '{3'd1, 16'h1234, 16'h1234, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}},
            '{3'd5, 16'h8001, 16'h0004, '{16'h0010, 1'b0, 1'b0, 1'b0, 1'b0}},
            '{3'd6, 16'h0009, 16'h0001, '{16'h0004, 1'b1, 1'b0, 1'b0, 1'b0}},
            '{3'd5, 16'h0003, 16'h000F, '{16'h8000, 1'b1, 1'b0, 1'b0, 1'b0}},
            '{3'd6, 16'hABCD, 16'h0000, '{16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0}},
            '{3'd0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}},
            '{3'd1, 16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0}},
            '{3'd2, 16'hF0F0, 16'hFF00, '{16'hF000, 1'b0, 1'b0, 1'b0, 1'b0}},
            '{3'd3, 16'h00F0, 16'h0F00, '{16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0}},
            '{3'd4, 16'hFFFF, 16'hFFFF, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}}
        };
        for (int i = 0; i < 12; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            total++;
            if ({done, busy, result, carry, zero, ovf, err} !== {2'b10, v[i].e}) begin
                $display("FAIL directed_%0d op=%0d a=%h b=%h: got %h expected %h", i, v[i].op,
                         v[i].a, v[i].b, {done, busy, result, carry, zero, ovf, err}, {2'b10, v[i].e});
            end else passed++;
        end
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         e;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = W'($urandom);
            e = model(o, x, y);
            issue(o, x, y);
            total++;
            if ({done, result, carry, zero, ovf, err} !== {1'b1, e}) begin
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h expected %h", i, o, x, y,
                         {done, result, carry, zero, ovf, err}, {1'b1, e});
            end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t         e;
        exp_t         last;
        last = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            o     = 3'($urandom_range(0, 6));
            x     = W'($urandom);
            y     = W'($urandom);
            e     = model(o, x, y);
            start = 1'b1;
            op    = o;
            a     = x;
            b     = y;
            @(posedge clk);
            #1;
            last = e;
            total++;
            if ({done, result, carry, zero, ovf, err} !== {1'b1, e}) begin
                $display("FAIL back_to_back_%0d op=%0d a=%h b=%h: got %h expected %h", i, o, x, y,
                         {done, result, carry, zero, ovf, err}, {1'b1, e});
            end else passed++;
        end
        start = 1'b0;
        // Result and flags hold, done drops, while inputs wander with start low.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = W'($urandom);
            @(posedge clk);
            #1;
            total++;
            if ({done, busy, result, carry, zero, ovf, err} !== {2'b00, last}) begin
                $display("FAIL hold_%0d: got %h expected %h", i,
                         {done, busy, result, carry, zero, ovf, err}, {2'b00, last});
            end else passed++;
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        @(negedge clk);
        start = 1'b1;
        op    = 3'd7;
        a     = 16'h0123;
        b     = 16'h0010;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            total++;
            if ({busy, done} !== 2'b10) begin
                $display("FAIL mul_busy_cycle_%0d: got busy,done=%b expected 10", i, {busy, done});
            end else passed++;
            @(negedge clk);
            if (i >= 2 && i < 9) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
                a     = W'($urandom);
                b     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if ({done, busy, result, carry, zero, ovf, err} !== {2'b10, 16'h1230, 4'b0000}) begin
            $display("FAIL mul_0123x0010: got %h expected %h",
                     {done, busy, result, carry, zero, ovf, err}, {2'b10, 16'h1230, 4'b0000});
        end else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL mul_done_single_pulse: got done,busy=%b expected 00", {done, busy});
        end else passed++;
        issue(3'd7, 16'h0100, 16'h0100);
        total++;
        if ({done, busy, result, carry, zero, ovf, err} !== {2'b10, 16'h0000, 4'b1110}) begin
            $display("FAIL mul_0100x0100: got %h expected %h",
                     {done, busy, result, carry, zero, ovf, err}, {2'b10, 16'h0000, 4'b1110});
        end else passed++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = 3'd7;
        a     = 16'hBEEF;
        b     = 16'h1357;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if ({busy, done, result, carry, zero, ovf, err} !== {2'b00, {W{1'b0}}, 4'b0100}) begin
            $display("FAIL reset_mid_mul: got %h expected %h",
                     {busy, done, result, carry, zero, ovf, err}, {2'b00, {W{1'b0}}, 4'b0100});
        end else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn  = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        a     = 16'h1111;
        b     = 16'h2222;
        e     = model(3'd0, 16'h1111, 16'h2222);
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if ({done, busy, result, carry, zero, ovf, err} !== {2'b10, e}) begin
            $display("FAIL add_after_reset: got %h expected %h",
                     {done, busy, result, carry, zero, ovf, err}, {2'b10, e});
        end else passed++;
        // The aborted multiply must never produce a late done pulse.
        for (int i = 0; i < W; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({done, busy, result} !== {2'b00, e.res}) begin
                $display("FAIL no_stale_mul_done_%0d: got %h expected %h", i,
                         {done, busy, result}, {2'b00, e.res});
            end else passed++;
        end
    endtask
`else
    task automatic test_mul_disabled();
        issue(3'd7, 16'h0123, 16'h0010);
        total++;
        if ({done, busy, result, carry, zero, ovf, err} !== {2'b10, 16'h0000, 4'b0101}) begin
            $display("FAIL mul_disabled: got %h expected %h",
                     {done, busy, result, carry, zero, ovf, err}, {2'b10, 16'h0000, 4'b0101});
        end else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({done, busy} !== 2'b00) begin
                $display("FAIL mul_disabled_idle_%0d: got done,busy=%b expected 00", i, {done, busy});
            end else passed++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        issue(3'd0, 16'h1234, 16'h0F0F);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if ({busy, done, result, carry, zero, ovf, err} !== {2'b00, {W{1'b0}}, 4'b0100}) begin
            $display("FAIL reset_async: got %h expected %h",
                     {busy, done, result, carry, zero, ovf, err}, {2'b00, {W{1'b0}}, 4'b0100});
        end else passed++;
        @(posedge clk);
        @(negedge clk);
        rstn  = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        a     = 16'h1111;
        b     = 16'h2222;
        e     = model(3'd0, 16'h1111, 16'h2222);
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if ({done, busy, result, carry, zero, ovf, err} !== {2'b10, e}) begin
            $display("FAIL add_after_reset: got %h expected %h",
                     {done, busy, result, carry, zero, ovf, err}, {2'b10, e});
        end else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
